// File: rtl/periph_bus_initiator.sv
// Pipelined XBAR_PERIPH_BUS initiator: command register, outstanding counter and in-order response FIFO.
// Define PERIPH_INIT_TIMEOUT_EN to build the response timeout, FLUSH/ERR recovery, err_o and clr_err_i.
module periph_bus_initiator #(
    parameter int ID_WIDTH  = 5,
    parameter int MASTER_ID = 1,
    parameter int MAX_OUTST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_wen_i,
    input  logic [31:0]         cmd_add_i,
    input  logic [31:0]         cmd_wdata_i,
    input  logic [3:0]          cmd_be_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_opc_o,
    output logic                per_req_o,
    input  logic                per_gnt_i,
    output logic [31:0]         per_add_o,
    output logic                per_wen_o,
    output logic [31:0]         per_wdata_o,
    output logic [3:0]          per_be_o,
    output logic [ID_WIDTH-1:0] per_id_o,
    input  logic                per_r_valid_i,
    input  logic                per_r_opc_i,
    input  logic [31:0]         per_r_rdata_i,
    input  logic [ID_WIDTH-1:0] per_r_id_i,
    output logic                busy_o,
    output logic                err_o,
    input  logic                clr_err_i,
    output logic [1:0]          dbg_state_o
);
    localparam int CW = $clog2(MAX_OUTST) + 1;
    localparam int AW = $clog2(MAX_OUTST);
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;
    localparam logic [31:0] FLUSH_DATA = 32'hDEAD_BEEF;

    logic [1:0]    state;
    logic          rdy_en;
    logic          req_q;
    logic [31:0]   add_q;
    logic [31:0]   wdata_q;
    logic          wen_q;
    logic [3:0]    be_q;
    logic [CW-1:0] outst;
    logic [CW-1:0] fifo_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [32:0]   fifo_mem [MAX_OUTST];
    logic          grant;
    logic          accept;
    logic          rsp_match;
    logic          flush_push;
    logic          push;
    logic          pop;
    logic [32:0]   push_data;
    logic [CW:0]   pending;

    // Handshakes: a transfer happens on an edge where valid && ready; payload holds while valid && !ready.
    // A granted request still counts against credit (it moves into outst), so every
    // request that can reach the bus already owns a FIFO slot for its response.
    assign grant      = req_q && per_gnt_i;
    assign rsp_match  = per_r_valid_i && (per_r_id_i == ID_WIDTH'(MASTER_ID)) &&
                        (outst != '0) && (state != ST_ERR);
    assign flush_push = (state == ST_FLUSH) && (outst != '0) && !rsp_match;
    assign push       = rsp_match || flush_push;
    assign push_data  = rsp_match ? {per_r_opc_i, per_r_rdata_i} : {1'b1, FLUSH_DATA};
    assign pop        = (fifo_cnt != '0) && rsp_ready_i;
    assign pending    = (CW+1)'(outst) + (CW+1)'(fifo_cnt) + (CW+1)'(req_q);
    assign cmd_ready_o = rdy_en && (state == ST_RUN) && (!req_q || per_gnt_i) &&
                         (pending < (CW+1)'(MAX_OUTST));
    assign accept     = cmd_valid_i && cmd_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdy_en <= 1'b0;
        else         rdy_en <= 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= 1'b0;
            add_q   <= '0;
            wen_q   <= 1'b1;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            req_q   <= 1'b1;
            add_q   <= cmd_add_i;
            wen_q   <= cmd_wen_i;
            wdata_q <= cmd_wdata_i;
            be_q    <= cmd_be_i;
        end else if (grant) begin
            req_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst    <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            outst    <= outst + CW'(grant) - CW'(push);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

`ifdef PERIPH_INIT_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_RUN;
            tmo_cnt <= '0;
        end else begin
            if ((outst == '0) || rsp_match) tmo_cnt <= '0;
            else if (state == ST_RUN)       tmo_cnt <= tmo_cnt + 16'd1;
            case (state)
                ST_RUN:   if ((outst != '0) && (tmo_cnt == 16'(TIMEOUT))) state <= ST_FLUSH;
                // wait for a stalled request to be granted so it is flushed too
                ST_FLUSH: if ((outst == '0) && !req_q) state <= ST_ERR;
                ST_ERR:   if (clr_err_i) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    assign err_o = (state == ST_ERR);
`else
    logic unused_clr;
    assign unused_clr = clr_err_i;
    assign state      = ST_RUN;
    assign err_o      = 1'b0;
`endif

    assign per_req_o   = req_q;
    assign per_add_o   = add_q;
    assign per_wen_o   = wen_q;
    assign per_wdata_o = wdata_q;
    assign per_be_o    = be_q;
    assign per_id_o    = ID_WIDTH'(MASTER_ID);
    assign rsp_valid_o = (fifo_cnt != '0);
    assign {rsp_opc_o, rsp_rdata_o} = fifo_mem[rd_ptr];
    assign busy_o      = req_q || (outst != '0) || (fifo_cnt != '0);
    assign dbg_state_o = state;
endmodule
